// File: rtl/dram_ctrl.sv
// ============================================================================
//  Module   : dram_ctrl
//  Brief    : MEM-stage data RAM responder with fixed-latency pipeline stall,
//             byte/halfword/word access and load extension.
//             Optional macro: DRAM_MISALIGN_CHECK_EN (suppress misaligned
//             halfword/word accesses and flag them on misalign).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          re,
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          misalign
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic          st_q;
  logic [31:0]   rdata_q;
  logic          mis_q;
  logic [31:0]   mem [DEPTH];

  logic          w_idle, w_req, w_acc, w_st, w_mis, w_wen;
  logic [IW+1:0] w_a;
  logic [IW-1:0] w_idx;
  logic [2:0]    w_f3;
  logic [31:0]   w_wd, w_word, w_sh, w_ld, w_wdat;
  logic [15:0]   w_half;
  logic [3:0]    w_be;
  logic          w_unused_addr;

  assign w_unused_addr = ^addr[AW-1:IW+2];
  assign w_idle = (state_q == IDLE);
  assign w_req  = re | we;

  // A single-cycle latency performs the access straight from the live inputs.
  assign w_acc = nrst & ((w_idle & w_req & (LATENCY == 1)) |
                         ((state_q == BUSY) & (cnt_q == C_LAST)));
  assign w_a   = w_idle ? addr[IW+1:0] : addr_q;
  assign w_f3  = w_idle ? funct3 : f3_q;
  assign w_wd  = w_idle ? wdata : wdata_q;
  assign w_st  = w_idle ? we : st_q;
  assign w_idx = w_a[IW+1:2];
  assign w_word = mem[w_idx];

`ifdef DRAM_MISALIGN_CHECK_EN
  logic w_is_half, w_is_word;
  assign w_is_half = w_st ? (w_f3 == 3'b001) : (w_f3[1:0] == 2'b01);
  assign w_is_word = w_st ? (w_f3[2:1] != 2'b00) : w_f3[1];
  assign w_mis = (w_is_half & w_a[0]) | (w_is_word & (w_a[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_sh   = w_word >> {w_a[1:0], 3'b000};
  assign w_half = w_a[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_f3)
      3'b000:  w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'h0, w_sh[7:0]};
      3'b101:  w_ld = {16'h0, w_half};
      default: w_ld = w_word;
    endcase
  end

  always_comb begin
    w_be   = 4'hF;
    w_wdat = w_wd;
    if (w_f3 == 3'b000) begin
      w_be   = 4'b0001 << w_a[1:0];
      w_wdat = {4{w_wd[7:0]}};
    end else if (w_f3 == 3'b001) begin
      w_be   = w_a[1] ? 4'b1100 : 4'b0011;
      w_wdat = {2{w_wd[15:0]}};
    end
  end

  assign w_wen = w_acc & w_st & ~w_mis;

  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (w_acc) begin
        mis_q <= w_mis;
        if (!w_st) rdata_q <= w_mis ? 32'h0 : w_ld;
      end
      unique case (state_q)
        IDLE: begin
          if (w_req) begin
            addr_q  <= addr[IW+1:0];
            wdata_q <= wdata;
            f3_q    <= funct3;
            st_q    <= we;
            if (LATENCY == 1) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= CW'(1);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == C_LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The request cycle stalls combinationally; reset forces the hold low at once.
  assign stall    = nrst & ((w_idle & w_req) | (state_q == BUSY));
  assign rdata    = rdata_q;
  assign misalign = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_ctrl.sv
// ============================================================================
//  Module   : tb_dram_ctrl
//  Brief    : Self-checking bench for dram_ctrl (LATENCY=2 and LATENCY=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_ctrl;

  logic        clk;
  logic        nrst;
  logic        re, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misalign;

  logic        re1, we1;
  logic [2:0]  f31;
  logic [31:0] addr1, wdata1, rdata1;
  logic        stall1, mis1;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_last;

  dram_ctrl #(.DEPTH(1024), .LATENCY(2), .AW(32)) u_dut (
    .clk(clk), .nrst(nrst), .re(re), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign)
  );

  dram_ctrl #(.DEPTH(1024), .LATENCY(1), .AW(32)) u_dut1 (
    .clk(clk), .nrst(nrst), .re(re1), .we(we1), .funct3(f31), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .stall(stall1), .misalign(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1 so consecutive calls issue back-to-back.
  task automatic op(input string nm, input logic st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_mis, input logic drop);
    re = ~st; we = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    chk({nm, " stall_c0"}, {31'h0, stall}, 32'h1);
    chk({nm, " mis_c0"}, {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
    if (drop) begin
      re = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    end
    @(negedge clk);
    chk({nm, " stall_c1"}, {31'h0, stall}, 32'h1);
    chk({nm, " mis_c1"}, {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, " stall_done"}, {31'h0, stall}, 32'h0);
    chk({nm, " rdata"}, rdata, exp_rd);
    chk({nm, " mis_done"}, {31'h0, misalign}, {31'h0, exp_mis});
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic        drop;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 3'b010, 32'h20,   32'h80F17F80, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'b000, 32'h20,   32'h0,        32'hFFFFFF80, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'b100, 32'h20,   32'h0,        32'h00000080, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'b000, 32'h21,   32'h0,        32'h0000007F, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'b001, 32'h22,   32'h0,        32'hFFFF80F1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'b101, 32'h22,   32'h0,        32'h000080F1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'b010, 32'h30,   32'h0,        32'h0,        1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'b000, 32'h33,   32'h000000AB, 32'h0,        1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'b001, 32'h30,   32'h00001234, 32'h0,        1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'b010, 32'h30,   32'h0,        32'hAB001234, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 3'b001, 32'h32,   32'hFFFF5678, 32'h0,        1'b0, 1'b1};
    tbl[13] = '{1'b0, 3'b111, 32'h30,   32'h0,        32'h56781234, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 3'b011, 32'h40,   32'h11223344, 32'h0,        1'b0, 1'b0};
    tbl[15] = '{1'b0, 3'b010, 32'h1040, 32'h0,        32'h11223344, 1'b0, 1'b0};
`ifdef DRAM_MISALIGN_CHECK_EN
    tbl[16] = '{1'b0, 3'b010, 32'h42,   32'h0,        32'h0,        1'b1, 1'b0};
    tbl[18] = '{1'b0, 3'b101, 32'h41,   32'h0,        32'h0,        1'b1, 1'b0};
`else
    tbl[16] = '{1'b0, 3'b010, 32'h42,   32'h0,        32'h11223344, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 3'b101, 32'h41,   32'h0,        32'h00003344, 1'b0, 1'b0};
`endif
    tbl[17] = '{1'b0, 3'b000, 32'h43,   32'h0,        32'h00000011, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 3'b000, 32'h31,   32'h123456CD, 32'h0,        1'b0, 1'b0};
    tbl[20] = '{1'b0, 3'b010, 32'h30,   32'h0,        32'h5678CD34, 1'b0, 1'b0};

    nrst = 1'b0; re = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    re1 = 1'b0; we1 = 1'b0; f31 = '0; addr1 = '0; wdata1 = '0;
    exp_last = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset rdata", rdata, 32'h0);
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset misalign", {31'h0, misalign}, 32'h0);
    nrst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      if (!tbl[i].st) exp_last = tbl[i].rd;
      op($sformatf("v%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
         exp_last, tbl[i].mis, tbl[i].drop);
    end

    // Reset during BUSY of a store: write must not land.
    we = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h5555AAAA;
    @(negedge clk);
    chk("rstbusy stall_c0", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy stall_c1", {31'h0, stall}, 32'h1);
    #2 nrst = 1'b0;
    #1;
    chk("rstbusy stall_async", {31'h0, stall}, 32'h0);
    chk("rstbusy rdata", rdata, 32'h0);
    we = 1'b0;
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;
    exp_last = 32'h11223344;
    op("after_rst lw40", 1'b0, 3'b010, 32'h40, 32'h0, exp_last, 1'b0, 1'b0);

    // LATENCY=1 instance: store, then hold a load request for four cycles.
    we1 = 1'b1; f31 = 3'b010; addr1 = 32'h8; wdata1 = 32'hCAFEF00D;
    @(negedge clk);
    chk("l1 st stall", {31'h0, stall1}, 32'h1);
    @(posedge clk); #1;
    we1 = 1'b0;
    @(negedge clk);
    chk("l1 st done stall", {31'h0, stall1}, 32'h0);
    chk("l1 st rdata", rdata1, 32'h0);
    @(posedge clk); #1;
    re1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("l1 held stall c%0d", c), {31'h0, stall1}, (c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("l1 held rdata c%0d", c), rdata1, (c == 0) ? 32'h0 : 32'hCAFEF00D);
      chk($sformatf("l1 held mis c%0d", c), {31'h0, mis1}, 32'h0);
      @(posedge clk); #1;
    end
    re1 = 1'b0;
    @(negedge clk);
    chk("l1 after stall", {31'h0, stall1}, 32'h0);
    chk("l1 after rdata", rdata1, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
